// File: rtl/ev22_pkg.sv
// Shared EV22 definitions: opcodes, sequencer states, register select codes
// and instruction field positions.
package ev22_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ALU  = 4'd1;
    localparam logic [3:0] OP_LDK  = 4'd2;
    localparam logic [3:0] OP_JMP  = 4'd3;
    localparam logic [3:0] OP_JZ   = 4'd4;
    localparam logic [3:0] OP_JNZ  = 4'd5;
    localparam logic [3:0] OP_MRD  = 4'd6;
    localparam logic [3:0] OP_MWR  = 4'd7;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [5:0] NOWR_SEL = 6'd63;
    localparam logic [5:0] W_SEL    = 6'd34;

    localparam int unsigned OP_MSB   = 31;
    localparam int unsigned OP_LSB   = 28;
    localparam int unsigned ALUC_MSB = 27;
    localparam int unsigned ALUC_LSB = 24;
    localparam int unsigned SELC_MSB = 23;
    localparam int unsigned SELC_LSB = 18;
    localparam int unsigned SELB_MSB = 17;
    localparam int unsigned SELB_LSB = 12;
    localparam int unsigned SELA_MSB = 11;
    localparam int unsigned SELA_LSB = 7;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_IMM,
        ST_EXEC,
        ST_MEM,
        ST_HALT
    } state_e;

endpackage

// File: rtl/ev22_instr_decode.sv
// Combinational EV22 instruction decoder: splits an instruction word into its
// fields and classifies the opcode.
module ev22_instr_decode
    import ev22_pkg::*;
(
    input  logic [31:7] ir_i,
    output logic [3:0]  op_o,
    output logic [3:0]  aluc_o,
    output logic [5:0]  sel_c_o,
    output logic [5:0]  sel_b_o,
    output logic [4:0]  sel_a_o,
    output logic        two_word_o,
    output logic        is_branch_o,
    output logic        is_mem_o,
    output logic        is_illegal_o
);

    always_comb begin
        op_o         = ir_i[OP_MSB:OP_LSB];
        aluc_o       = ir_i[ALUC_MSB:ALUC_LSB];
        sel_c_o      = ir_i[SELC_MSB:SELC_LSB];
        sel_b_o      = ir_i[SELB_MSB:SELB_LSB];
        sel_a_o      = ir_i[SELA_MSB:SELA_LSB];
        two_word_o   = (op_o == OP_LDK) || (op_o == OP_JMP) ||
                       (op_o == OP_JZ)  || (op_o == OP_JNZ);
        is_branch_o  = (op_o == OP_JMP) || (op_o == OP_JZ) || (op_o == OP_JNZ);
        is_mem_o     = (op_o == OP_MRD) || (op_o == OP_MWR);
        is_illegal_o = (op_o > OP_MWR) && (op_o != OP_HALT);
    end

endmodule

// File: rtl/ev22_sequencer.sv
// EV22 fetch/decode/execute sequencer: fetches instruction words, drives the
// register-bank selects, ALU control and memory strobes, and sequences jumps.
module ev22_sequencer
    import ev22_pkg::*;
#(
    parameter int unsigned PC_W     = 12,
    parameter logic [5:0]  NOWR_SEL = ev22_pkg::NOWR_SEL
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_rd,
    input  logic [31:0]     imem_data,
    input  logic            imem_ready,
    input  logic            dmem_ready,
    input  logic            alu_z,
    output logic [4:0]      sel_a,
    output logic [5:0]      sel_b,
    output logic [5:0]      sel_c,
    output logic [3:0]      aluc,
    output logic            kmux,
    output logic [15:0]     k_out,
    output logic            mr,
    output logic            mw,
    output logic            halted,
    output logic            illegal
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:7]     ir_q, ir_d;
    logic [15:0]     imm_q, imm_d;
    logic            z_q, z_d;

    logic            rd_q, rd_d;
    logic [4:0]      sel_a_q, sel_a_d;
    logic [5:0]      sel_b_q, sel_b_d;
    logic [5:0]      sel_c_q, sel_c_d;
    logic [3:0]      aluc_q, aluc_d;
    logic            kmux_q, kmux_d;
    logic [15:0]     k_q, k_d;
    logic            mr_q, mr_d;
    logic            mw_q, mw_d;
    logic            halted_q, halted_d;
    logic            illegal_q, illegal_d;

    logic [3:0]      dec_op, dec_aluc;
    logic [5:0]      dec_sel_c, dec_sel_b;
    logic [4:0]      dec_sel_a;
    logic            dec_two_word, dec_branch, dec_mem, dec_illegal;
    logic            taken;

    // The decoder looks at the next IR so the registered outputs line up with
    // the EXEC cycle; outside a fetch, ir_d simply equals ir_q.
    always_comb begin
        ir_d = ir_q;
        if (state_q == ST_FETCH && imem_ready) ir_d = imem_data[31:7];
    end

    ev22_instr_decode u_decode (
        .ir_i         (ir_d),
        .op_o         (dec_op),
        .aluc_o       (dec_aluc),
        .sel_c_o      (dec_sel_c),
        .sel_b_o      (dec_sel_b),
        .sel_a_o      (dec_sel_a),
        .two_word_o   (dec_two_word),
        .is_branch_o  (dec_branch),
        .is_mem_o     (dec_mem),
        .is_illegal_o (dec_illegal)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        imm_d   = imm_q;
        z_d     = z_q;
        taken   = (dec_op == OP_JMP) || (dec_op == OP_JZ && z_q) ||
                  (dec_op == OP_JNZ && !z_q);
        unique case (state_q)
            ST_FETCH: begin
                if (imem_ready) begin
                    pc_d    = pc_q + PC_W'(1);
                    state_d = dec_two_word ? ST_IMM : ST_EXEC;
                end
            end
            ST_IMM: begin
                if (imem_ready) begin
                    imm_d   = imem_data[15:0];
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                if (dec_op == OP_ALU || dec_op == OP_LDK) z_d = alu_z;
                if (dec_branch && taken) pc_d = imm_q[PC_W-1:0];
                if (dec_mem) state_d = ST_MEM;
                if (dec_op == OP_HALT) state_d = ST_HALT;
            end
            ST_MEM: begin
                if (dmem_ready) state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        rd_d      = (state_d == ST_FETCH) || (state_d == ST_IMM);
        sel_a_d   = '0;
        sel_b_d   = '0;
        sel_c_d   = NOWR_SEL;
        aluc_d    = '0;
        kmux_d    = 1'b0;
        k_d       = '0;
        mr_d      = 1'b0;
        mw_d      = 1'b0;
        halted_d  = 1'b0;
        illegal_d = 1'b0;
        unique case (state_d)
            ST_EXEC: begin
                illegal_d = dec_illegal;
                if (dec_op == OP_ALU || dec_op == OP_LDK) begin
                    sel_a_d = dec_sel_a;
                    sel_b_d = dec_sel_b;
                    sel_c_d = dec_sel_c;
                    aluc_d  = dec_aluc;
                end
                if (dec_op == OP_LDK) begin
                    kmux_d = 1'b1;
                    k_d    = imm_d;
                end
            end
            ST_MEM: begin
                mr_d = (dec_op == OP_MRD);
                mw_d = (dec_op == OP_MWR);
            end
            ST_HALT: halted_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            pc_q      <= '0;
            ir_q      <= '0;
            imm_q     <= '0;
            z_q       <= 1'b0;
            rd_q      <= 1'b1;
            sel_a_q   <= '0;
            sel_b_q   <= '0;
            sel_c_q   <= NOWR_SEL;
            aluc_q    <= '0;
            kmux_q    <= 1'b0;
            k_q       <= '0;
            mr_q      <= 1'b0;
            mw_q      <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            imm_q     <= imm_d;
            z_q       <= z_d;
            rd_q      <= rd_d;
            sel_a_q   <= sel_a_d;
            sel_b_q   <= sel_b_d;
            sel_c_q   <= sel_c_d;
            aluc_q    <= aluc_d;
            kmux_q    <= kmux_d;
            k_q       <= k_d;
            mr_q      <= mr_d;
            mw_q      <= mw_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    assign imem_addr = pc_q;
    assign imem_rd   = rd_q;
    assign sel_a     = sel_a_q;
    assign sel_b     = sel_b_q;
    assign sel_c     = sel_c_q;
    assign aluc      = aluc_q;
    assign kmux      = kmux_q;
    assign k_out     = k_q;
    assign mr        = mr_q;
    assign mw        = mw_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_ev22_sequencer.sv
// Directed self-checking bench for ev22_sequencer with a simple program memory
// model whose ready line is controlled by the bench.
module tb_ev22_sequencer;

    logic        clk;
    logic        reset;
    logic [11:0] imem_addr;
    logic        imem_rd;
    logic [31:0] imem_data;
    logic        imem_ready;
    logic        dmem_ready;
    logic        alu_z;
    logic [4:0]  sel_a;
    logic [5:0]  sel_b;
    logic [5:0]  sel_c;
    logic [3:0]  aluc;
    logic        kmux;
    logic [15:0] k_out;
    logic        mr;
    logic        mw;
    logic        halted;
    logic        illegal;

    logic [31:0] mem [0:4095];
    logic        ready_en;
    int          checks;
    int          errors;

    assign imem_data  = mem[imem_addr];
    assign imem_ready = ready_en;

    ev22_sequencer #(.PC_W(12), .NOWR_SEL(6'd63)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_rd    (imem_rd),
        .imem_data  (imem_data),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .alu_z      (alu_z),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .sel_c      (sel_c),
        .aluc       (aluc),
        .kmux       (kmux),
        .k_out      (k_out),
        .mr         (mr),
        .mw         (mw),
        .halted     (halted),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] ac,
                                       input logic [5:0] sc, input logic [5:0] sb,
                                       input logic [4:0] sa);
        return {op, ac, sc, sb, sa, 7'h00};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem;
        for (int i = 0; i < 4096; i++) mem[i] = 32'hF000_0000;
    endtask

    task automatic do_reset;
        reset      = 1'b1;
        ready_en   = 1'b1;
        dmem_ready = 1'b0;
        alu_z      = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        clear_mem();
        reset = 1'b1; ready_en = 1'b1; dmem_ready = 1'b0; alu_z = 1'b0;
        step();
        step();
        checks++; if (imem_addr !== 12'h000) begin errors++; $display("FAIL reset_addr got %0h want 0", imem_addr); end
        checks++; if (imem_rd !== 1'b1) begin errors++; $display("FAIL reset_rd got %0b want 1", imem_rd); end
        checks++; if (sel_c !== 6'd63) begin errors++; $display("FAIL reset_selc got %0d want 63", sel_c); end
        checks++;
        if ({sel_a, sel_b, aluc, kmux, k_out, mr, mw, halted, illegal} !== '0) begin
            errors++;
            $display("FAIL reset_zero got sel_a=%0d sel_b=%0d aluc=%0d kmux=%0b k=%0h mr=%0b mw=%0b halted=%0b illegal=%0b want all 0",
                     sel_a, sel_b, aluc, kmux, k_out, mr, mw, halted, illegal);
        end
        reset = 1'b0;
    endtask

    task automatic test_alu;
        clear_mem();
        mem[0] = mk(4'd1, 4'd3, 6'd5, 6'd1, 5'd2);
        do_reset();
        checks++; if (imem_addr !== 12'h000 || imem_rd !== 1'b1) begin errors++; $display("FAIL alu_fetch0 got addr=%0h rd=%0b want 0/1", imem_addr, imem_rd); end
        step();
        checks++;
        if ({sel_a, sel_b, sel_c, aluc, kmux} !== {5'd2, 6'd1, 6'd5, 4'd3, 1'b0}) begin
            errors++;
            $display("FAIL alu_exec got a=%0d b=%0d c=%0d aluc=%0d kmux=%0b want 2/1/5/3/0", sel_a, sel_b, sel_c, aluc, kmux);
        end
        checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL alu_exec_rd got %0b want 0", imem_rd); end
        step();
        checks++;
        if (imem_addr !== 12'h001 || imem_rd !== 1'b1 || sel_c !== 6'd63) begin
            errors++;
            $display("FAIL alu_fetch1 got addr=%0h rd=%0b selc=%0d want 1/1/63", imem_addr, imem_rd, sel_c);
        end
    endtask

    task automatic test_ldk;
        clear_mem();
        mem[0] = mk(4'd2, 4'd4, 6'd34, 6'd7, 5'd3);
        mem[1] = 32'hFFFF_00AB;
        do_reset();
        step();
        checks++;
        if (imem_addr !== 12'h001 || imem_rd !== 1'b1 || sel_c !== 6'd63) begin
            errors++;
            $display("FAIL ldk_imm got addr=%0h rd=%0b selc=%0d want 1/1/63", imem_addr, imem_rd, sel_c);
        end
        step();
        checks++;
        if ({kmux, k_out, sel_c, sel_b, sel_a, aluc} !== {1'b1, 16'h00AB, 6'd34, 6'd7, 5'd3, 4'd4}) begin
            errors++;
            $display("FAIL ldk_exec got kmux=%0b k=%0h c=%0d b=%0d a=%0d aluc=%0d want 1/ab/34/7/3/4",
                     kmux, k_out, sel_c, sel_b, sel_a, aluc);
        end
        step();
        checks++; if (imem_addr !== 12'h002 || kmux !== 1'b0 || k_out !== 16'h0) begin errors++; $display("FAIL ldk_next got addr=%0h kmux=%0b k=%0h want 2/0/0", imem_addr, kmux, k_out); end
    endtask

    task automatic run_branch(input logic [3:0] op, input logic z, input logic [11:0] exp_addr, input string name);
        clear_mem();
        mem[0] = mk(4'd1, 4'd1, 6'd1, 6'd2, 5'd3);
        mem[1] = mk(op, 4'd5, 6'd9, 6'd9, 5'd9);
        mem[2] = 32'h0000_0040;
        do_reset();
        step();
        alu_z = z;
        step();
        alu_z = ~z;
        step();
        step();
        checks++;
        if (sel_c !== 6'd63 || aluc !== 4'd0) begin
            errors++;
            $display("FAIL %s_exec got selc=%0d aluc=%0d want 63/0", name, sel_c, aluc);
        end
        step();
        checks++; if (imem_addr !== exp_addr) begin errors++; $display("FAIL %s_target got %0h want %0h", name, imem_addr, exp_addr); end
    endtask

    task automatic test_branch;
        run_branch(4'd4, 1'b1, 12'h040, "jz_taken");
        run_branch(4'd4, 1'b0, 12'h003, "jz_fall");
        run_branch(4'd5, 1'b1, 12'h003, "jnz_fall");
        run_branch(4'd5, 1'b0, 12'h040, "jnz_taken");
    endtask

    task automatic test_mem;
        clear_mem();
        mem[0] = mk(4'd7, 4'd2, 6'd5, 6'd1, 5'd1);
        do_reset();
        step();
        checks++; if (mw !== 1'b0 || sel_c !== 6'd63) begin errors++; $display("FAIL mwr_exec got mw=%0b selc=%0d want 0/63", mw, sel_c); end
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mw !== 1'b1 || mr !== 1'b0) begin errors++; $display("FAIL mwr_hold%0d got mw=%0b mr=%0b want 1/0", i, mw, mr); end
            if (i == 3) dmem_ready = 1'b1;
            step();
        end
        dmem_ready = 1'b0;
        checks++;
        if (mw !== 1'b0 || imem_rd !== 1'b1 || imem_addr !== 12'h001) begin
            errors++;
            $display("FAIL mwr_done got mw=%0b rd=%0b addr=%0h want 0/1/1", mw, imem_rd, imem_addr);
        end
        clear_mem();
        mem[0] = mk(4'd6, 4'd0, 6'd0, 6'd0, 5'd0);
        do_reset();
        dmem_ready = 1'b1;
        step();
        step();
        checks++; if (mr !== 1'b1 || mw !== 1'b0) begin errors++; $display("FAIL mrd_mem got mr=%0b mw=%0b want 1/0", mr, mw); end
        step();
        checks++; if (mr !== 1'b0 || imem_addr !== 12'h001 || imem_rd !== 1'b1) begin errors++; $display("FAIL mrd_done got mr=%0b addr=%0h rd=%0b want 0/1/1", mr, imem_addr, imem_rd); end
        dmem_ready = 1'b0;
    endtask

    task automatic test_illegal_halt;
        clear_mem();
        mem[0] = mk(4'd9, 4'd2, 6'd5, 6'd1, 5'd1);
        do_reset();
        step();
        checks++; if (illegal !== 1'b1 || sel_c !== 6'd63) begin errors++; $display("FAIL ill_exec got illegal=%0b selc=%0d want 1/63", illegal, sel_c); end
        step();
        checks++; if (illegal !== 1'b0 || imem_addr !== 12'h001) begin errors++; $display("FAIL ill_after got illegal=%0b addr=%0h want 0/1", illegal, imem_addr); end
        step();
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_exec got halted=%0b want 0", halted); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({halted, imem_rd, mr, mw} !== 4'b1000 || imem_addr !== 12'h002) begin
                errors++;
                $display("FAIL halt_hold%0d got halted=%0b rd=%0b mr=%0b mw=%0b addr=%0h want 1/0/0/0/2",
                         i, halted, imem_rd, mr, mw, imem_addr);
            end
        end
    endtask

    task automatic test_reset_mid_mem;
        clear_mem();
        mem[0] = mk(4'd7, 4'd0, 6'd0, 6'd0, 5'd0);
        do_reset();
        step();
        step();
        checks++; if (mw !== 1'b1) begin errors++; $display("FAIL midmem_pre got mw=%0b want 1", mw); end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (mw !== 1'b0 || imem_rd !== 1'b1 || imem_addr !== 12'h000 || sel_c !== 6'd63) begin
            errors++;
            $display("FAIL midmem_reset got mw=%0b rd=%0b addr=%0h selc=%0d want 0/1/0/63", mw, imem_rd, imem_addr, sel_c);
        end
        step();
        reset = 1'b0;
        step();
        checks++; if (imem_addr !== 12'h001 || mw !== 1'b0) begin errors++; $display("FAIL midmem_restart got addr=%0h mw=%0b want 1/0", imem_addr, mw); end
    endtask

    task automatic test_wrap;
        clear_mem();
        mem[0]      = mk(4'd3, 4'd0, 6'd0, 6'd0, 5'd0);
        mem[1]      = 32'h0000_1FFF;
        mem[12'hFFF] = mk(4'd1, 4'd2, 6'd4, 6'd5, 5'd6);
        do_reset();
        step();
        step();
        step();
        checks++; if (imem_addr !== 12'hFFF || imem_rd !== 1'b1) begin errors++; $display("FAIL wrap_jmp got addr=%0h rd=%0b want fff/1", imem_addr, imem_rd); end
        step();
        checks++; if (sel_c !== 6'd4 || aluc !== 4'd2) begin errors++; $display("FAIL wrap_exec got selc=%0d aluc=%0d want 4/2", sel_c, aluc); end
        step();
        checks++; if (imem_addr !== 12'h000 || imem_rd !== 1'b1) begin errors++; $display("FAIL wrap_next got addr=%0h rd=%0b want 0/1", imem_addr, imem_rd); end
        do_reset();
        step();
        step();
        step();
        ready_en = 1'b0;
        step();
        step();
        checks++; if (imem_addr !== 12'hFFF || imem_rd !== 1'b1) begin errors++; $display("FAIL wrap_stall got addr=%0h rd=%0b want fff/1", imem_addr, imem_rd); end
        reset = 1'b1;
        #1;
        checks++; if (imem_addr !== 12'h000 || imem_rd !== 1'b1) begin errors++; $display("FAIL wrap_reset got addr=%0h rd=%0b want 0/1", imem_addr, imem_rd); end
        ready_en = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        ready_en   = 1'b1;
        dmem_ready = 1'b0;
        alu_z      = 1'b0;
        test_reset();
        test_alu();
        test_ldk();
        test_branch();
        test_mem();
        test_illegal_halt();
        test_reset_mid_mem();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
